// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential BCD-to-binary converter:
// digit constants, FSM state encoding and a parameter sizing helper.
package bcd_pkg;

  localparam int         BCD_DIGIT_W = 4;
  localparam logic [3:0] BCD_MAX     = 4'd9;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Largest decimal value representable with the given number of digits.
  function automatic longint unsigned dec_max(input int digits);
    longint unsigned v;
    v = 64'd1;
    for (int i = 0; i < digits; i++) begin
      v = v * 64'd10;
    end
    return v - 64'd1;
  endfunction

endpackage

// File: rtl/bcd_mac_step.sv
// One decimal multiply-accumulate step: nxt = acc*10 + digit, flagging digits above 9.
// The digit is used unclamped; overflow from bad digits simply truncates.
module bcd_mac_step
  import bcd_pkg::*;
#(
  parameter int BIN_W = 14
) (
  input  logic [BIN_W-1:0]       acc,
  input  logic [BCD_DIGIT_W-1:0] digit,
  output logic [BIN_W-1:0]       nxt,
  output logic                   bad
);

  localparam int EXT_W = BIN_W + 4;

  logic [EXT_W-1:0] acc_ext;

  assign acc_ext = EXT_W'(acc);
  assign nxt     = BIN_W'((acc_ext << 3) + (acc_ext << 1) + EXT_W'(digit));
  assign bad     = (digit > BCD_MAX);

endmodule

// File: rtl/bcd_bin_seq.sv
// Sequential BCD-to-binary converter: one shared acc*10+digit step per cycle,
// most-significant digit first, with valid/ready on both sides and a synchronous flush.
//
// state  | meaning
// S_IDLE | ready for a request; last result held on bin_out/err
// S_CONV | one digit folded into acc per cycle, DIGITS cycles
// S_DONE | result presented with out_valid until out_ready
module bcd_bin_seq
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14,
  parameter int CNT_W  = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [4*DIGITS-1:0]     bcd_in,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [BIN_W-1:0]        bin_out,
  output logic                    err
);

  localparam int SH_W = BCD_DIGIT_W * DIGITS;

  if (DIGITS < 2) begin : g_digits_chk
    $error("bcd_bin_seq: DIGITS must be at least 2");
  end
  if (BIN_W < 64) begin : g_bin_w_chk
    if ((64'd1 << BIN_W) <= dec_max(DIGITS)) begin : g_too_narrow
      $error("bcd_bin_seq: BIN_W cannot hold the largest DIGITS-digit decimal value");
    end
  end
  if ((1 << CNT_W) <= DIGITS) begin : g_cnt_w_chk
    $error("bcd_bin_seq: CNT_W too narrow to count DIGITS steps");
  end

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIGITS - 1);

  state_e             state_q, state_d;
  logic [SH_W-1:0]    sh_q, sh_d;
  logic [BIN_W-1:0]   acc_q, acc_d;
  logic               err_acc_q, err_acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic               err_q, err_d;

  logic [BIN_W-1:0]   mac_nxt;
  logic               mac_bad;

  bcd_mac_step #(
    .BIN_W (BIN_W)
  ) u_mac (
    .acc   (acc_q),
    .digit (sh_q[SH_W-1 -: BCD_DIGIT_W]),
    .nxt   (mac_nxt),
    .bad   (mac_bad)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      sh_q      <= '0;
      acc_q     <= '0;
      err_acc_q <= 1'b0;
      cnt_q     <= '0;
      bin_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sh_q      <= sh_d;
      acc_q     <= acc_d;
      err_acc_q <= err_acc_d;
      cnt_q     <= cnt_d;
      bin_q     <= bin_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    sh_d      = sh_q;
    acc_d     = acc_q;
    err_acc_d = err_acc_q;
    cnt_d     = cnt_q;
    bin_d     = bin_q;
    err_d     = err_q;

    // Flush abandons any work but leaves the last published result visible.
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            sh_d      = bcd_in;
            acc_d     = '0;
            err_acc_d = 1'b0;
            cnt_d     = '0;
            state_d   = S_CONV;
          end
        end
        S_CONV: begin
          acc_d     = mac_nxt;
          sh_d      = sh_q << BCD_DIGIT_W;
          err_acc_d = err_acc_q | mac_bad;
          cnt_d     = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            bin_d   = mac_nxt;
            err_d   = err_acc_q | mac_bad;
            state_d = S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_d = S_IDLE;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // in_ready is held low while reset is asserted, even though the state already reads IDLE.
  assign in_ready  = rst_n && (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign bin_out   = bin_q;
  assign err       = err_q;

endmodule

// File: tb/tb_bcd_bin_seq.sv
// Randomised bench for bcd_bin_seq against a decimal arithmetic reference model.
module tb_bcd_bin_seq;

  localparam int DIGITS = 4;
  localparam int BIN_W  = 14;
  localparam int CNT_W  = 3;

  logic                clk;
  logic                rst_n;
  logic                in_valid;
  logic                in_ready;
  logic [4*DIGITS-1:0] bcd_in;
  logic                flush;
  logic                out_valid;
  logic                out_ready;
  logic [BIN_W-1:0]    bin_out;
  logic                err;

  int n_chk;
  int n_fail;

  logic [BIN_W-1:0] last_bin;
  logic             last_err;

  bcd_bin_seq #(
    .DIGITS (DIGITS),
    .BIN_W  (BIN_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bcd_in    (bcd_in),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .bin_out   (bin_out),
    .err       (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, got, got, exp, exp, $time);
    end
  endtask

  // Decimal value of the packed digits, reduced modulo 2**BIN_W; err if any digit exceeds 9.
  task automatic model(input logic [4*DIGITS-1:0] b, output logic [BIN_W-1:0] bin, output logic e);
    longint unsigned v;
    int d;
    v = 0;
    e = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      d = int'(b[4*i +: 4]);
      if (d > 9) e = 1'b1;
      v = v * 10 + longint'(d);
    end
    bin = BIN_W'(v % (64'd1 << BIN_W));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_conv(input logic [4*DIGITS-1:0] bcd, input int hold, input logic junk);
    logic [BIN_W-1:0] eb;
    logic             ee;
    int               edges;
    model(bcd, eb, ee);
    chk("in_ready_idle", 32'(in_ready), 1);
    bcd_in    = bcd;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    tick();
    in_valid = 1'b0;
    edges    = 0;
    while (!out_valid && edges <= 20) begin
      chk("in_ready_busy", 32'(in_ready), 0);
      if (junk) begin
        in_valid = 1'($urandom_range(0, 1));
        bcd_in   = 16'($urandom);
      end
      tick();
      edges++;
    end
    in_valid = 1'b0;
    chk("latency", edges, DIGITS);
    chk("bin_out", 32'(bin_out), 32'(eb));
    chk("err", 32'(err), 32'(ee));
    for (int k = 0; k < hold; k++) begin
      tick();
      chk("bp_valid", 32'(out_valid), 1);
      chk("bp_bin", 32'(bin_out), 32'(eb));
      chk("bp_err", 32'(err), 32'(ee));
      chk("bp_in_ready", 32'(in_ready), 0);
      if (k == hold - 1) out_ready = 1'b1;
    end
    tick();
    chk("release_valid", 32'(out_valid), 0);
    chk("release_ready", 32'(in_ready), 1);
    chk("idle_bin_held", 32'(bin_out), 32'(eb));
    chk("idle_err_held", 32'(err), 32'(ee));
    out_ready = 1'b0;
    last_bin  = eb;
    last_err  = ee;
  endtask

  task automatic expect_quiet(input int cycles, input string tag);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (out_valid) seen++;
    end
    chk(tag, seen, 0);
  endtask

  function automatic logic [4*DIGITS-1:0] rand_bcd();
    logic [4*DIGITS-1:0] b;
    for (int i = 0; i < DIGITS; i++) begin
      if ($urandom_range(0, 9) == 0) b[4*i +: 4] = 4'($urandom_range(10, 15));
      else                           b[4*i +: 4] = 4'($urandom_range(0, 9));
    end
    return b;
  endfunction

  initial begin
    n_chk     = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    bcd_in    = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    last_bin  = '0;
    last_err  = 1'b0;

    #1;
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_bin", 32'(bin_out), 0);
    chk("rst_err", 32'(err), 0);
    #21;
    rst_n = 1'b1;
    tick();
    chk("post_rst_in_ready", 32'(in_ready), 1);
    chk("post_rst_out_valid", 32'(out_valid), 0);

    run_conv(16'h1234, 0, 1'b0);
    chk("basic_value", 32'(last_bin), 1234);
    run_conv(16'h0000, 0, 1'b0);
    run_conv(16'h9999, 0, 1'b0);
    chk("max_value", 32'(last_bin), 32'h270F);
    run_conv(16'h12A4, 0, 1'b0);
    chk("invalid_value", 32'(last_bin), 1304);
    chk("invalid_err", 32'(last_err), 1);
    run_conv(16'hFFFF, 1, 1'b0);
    run_conv(16'h0815, 3, 1'b1);

    // Flush on the second CONV cycle.
    bcd_in   = 16'h5678;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_out_valid", 32'(out_valid), 0);
    chk("flush_in_ready", 32'(in_ready), 1);
    chk("flush_bin_held", 32'(bin_out), 32'(last_bin));
    chk("flush_err_held", 32'(err), 32'(last_err));
    expect_quiet(DIGITS + 3, "flush_no_result");

    // Flush coinciding with a handshake drops the request.
    bcd_in   = 16'h4321;
    in_valid = 1'b1;
    flush    = 1'b1;
    tick();
    in_valid = 1'b0;
    flush    = 1'b0;
    chk("flush_hs_in_ready", 32'(in_ready), 1);
    expect_quiet(DIGITS + 3, "flush_hs_dropped");
    run_conv(16'h0042, 0, 1'b0);
    chk("after_flush_value", 32'(last_bin), 42);

    // Async reset in the middle of a conversion.
    run_conv(16'h0777, 0, 1'b0);
    bcd_in   = 16'h7531;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 0);
    chk("mid_rst_bin", 32'(bin_out), 0);
    chk("mid_rst_err", 32'(err), 0);
    chk("mid_rst_in_ready", 32'(in_ready), 0);
    #4;
    rst_n = 1'b1;
    tick();
    chk("rst_release_in_ready", 32'(in_ready), 1);
    expect_quiet(DIGITS + 2, "rst_no_result");
    run_conv(16'h2468, 0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      run_conv(rand_bcd(), int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
